divider_nr_seq: RTL and testbench

//  Iterative, parametrised non-restoring integer divider with valid/ready handshakes.

---
 rtl/divider_nr_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_divider_nr_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_nr_seq.sv
// divider_nr_seq
//   Iterative non-restoring integer divider with valid/ready handshakes on both
//   sides. Resolves IPC quotient bits per clock, so a normal division occupies
//   DW/IPC CALC cycles plus one FIX cycle. Supports unsigned and signed
//   (truncating) division. Divide-by-zero and signed overflow are resolved at
//   accept time without iterating.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   request valid
//   in_ready   out  1   block idle and able to accept a request
//   dividend   in   DW  dividend A
//   divisor    in   VW  divisor B
//   sgn        in   1   1 = two's-complement operands, 0 = unsigned
//   flush      in   1   synchronous abort of whatever is in flight
//   out_valid  out  1   result valid (held until out_ready)
//   out_ready  in   1   consumer accepts the result
//   quotient   out  DW  quotient
//   remainder  out  VW  remainder
//   dz         out  1   divisor was zero
//   ovf        out  1   signed most-negative / -1
module divider_nr_seq #(
  parameter int DW  = 32,
  parameter int VW  = 16,
  parameter int IPC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  input  logic          sgn,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz,
  output logic          ovf
);

  localparam int N  = DW / IPC;          // CALC cycles per division
  localparam int CW = $clog2(N + 1);     // iteration counter width
  localparam int PW = VW + 2;            // signed partial remainder width

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] prem_q, prem_d;
  // Holds the dividend magnitude; its MSBs shift into prem while quotient
  // bits shift in at the bottom, so it ends CALC holding |quotient|.
  logic [DW-1:0] acc_q, acc_d;
  logic [VW-1:0] bmag_q, bmag_d;
  logic          negq_q, negq_d;        // quotient must be negated
  logic          negr_q, negr_d;        // remainder must be negated
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Operand decode at the input boundary
  // ---------------------------------------------------------------------------
  logic          a_neg, b_neg;
  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  logic          is_dz, is_ovf;

  assign a_neg  = sgn & dividend[DW-1];
  assign b_neg  = sgn & divisor[VW-1];
  // The most-negative value negates to itself, which is its correct
  // unsigned magnitude.
  assign a_mag  = a_neg ? -dividend : dividend;
  assign b_mag  = b_neg ? -divisor  : divisor;
  assign is_dz  = (divisor == '0);
  assign is_ovf = sgn && (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == {VW{1'b1}});

  // ---------------------------------------------------------------------------
  // IPC non-restoring steps per clock
  // ---------------------------------------------------------------------------
  logic [PW-1:0] bext;
  logic [PW-1:0] step_prem;
  logic [DW-1:0] step_acc;
  logic [PW-1:0] p_v;
  logic [DW-1:0] a_v;

  assign bext = {2'b00, bmag_q};

  always_comb begin
    p_v = prem_q;
    a_v = acc_q;
    for (int i = 0; i < IPC; i++) begin
      // prem stays within [-|B|, |B|) so the shift never disturbs its sign.
      p_v = {p_v[PW-2:0], a_v[DW-1]};
      a_v = {a_v[DW-2:0], 1'b0};
      if (p_v[PW-1]) begin
        p_v = p_v + bext;
      end else begin
        p_v = p_v - bext;
      end
      a_v[0] = ~p_v[PW-1];
    end
    step_prem = p_v;
    step_acc  = a_v;
  end

  // ---------------------------------------------------------------------------
  // Final correction and sign application
  // ---------------------------------------------------------------------------
  logic [VW-1:0] rem_mag;
  logic [DW-1:0] fix_quot;
  logic [VW-1:0] fix_rem;

  // The corrected remainder lies in [0, |B|) so its low VW bits are exact.
  assign rem_mag  = prem_q[VW-1:0] + (prem_q[PW-1] ? bmag_q : '0);
  assign fix_quot = negq_q ? -acc_q : acc_q;
  assign fix_rem  = negr_q ? -rem_mag : rem_mag;

  // ---------------------------------------------------------------------------
  // FSM next state and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    acc_d   = acc_q;
    bmag_d  = bmag_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    if (flush) begin
      // Abort wins over any coincident accept or output handshake.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            prem_d = '0;
            acc_d  = a_mag;
            bmag_d = b_mag;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            cnt_d  = '0;
            if (is_dz) begin
              dz_d    = 1'b1;
              ovf_d   = 1'b0;
              quot_d  = '1;
              rem_d   = dividend[VW-1:0];
              state_d = S_DONE;
            end else if (is_ovf) begin
              dz_d    = 1'b0;
              ovf_d   = 1'b1;
              quot_d  = dividend;
              rem_d   = '0;
              state_d = S_DONE;
            end else begin
              dz_d    = 1'b0;
              ovf_d   = 1'b0;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          prem_d = step_prem;
          acc_d  = step_acc;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          quot_d  = fix_quot;
          rem_d   = fix_rem;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      acc_q   <= '0;
      bmag_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      acc_q   <= acc_d;
      bmag_q  <= bmag_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider_nr_seq.sv
module tb_divider_nr_seq;

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        sgn;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        dz, ovf;

  // second instance with 4 quotient bits per clock
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [31:0] quotient4;
  logic [15:0] remainder4;
  logic        dz4, ovf4;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  res_t exp_q[$];

  divider_nr_seq #(.DW(32), .VW(16), .IPC(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .sgn(sgn), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .dz(dz), .ovf(ovf)
  );

  divider_nr_seq #(.DW(32), .VW(16), .IPC(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .dividend(dividend), .divisor(divisor), .sgn(sgn), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .quotient(quotient4), .remainder(remainder4), .dz(dz4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endfunction

  // Reference: plain integer arithmetic with the special cases stated directly.
  function automatic res_t model(input logic [31:0] a, input logic [15:0] b, input logic s);
    res_t   res;
    longint sa, sb, qq, rr;
    res = '0;
    if (b == 16'h0) begin
      res.q  = 32'hFFFF_FFFF;
      res.r  = a[15:0];
      res.dz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 16'hFFFF) begin
      res.q   = a;
      res.r   = 16'h0;
      res.ovf = 1'b1;
    end else if (!s) begin
      qq    = longint'(a) / longint'(b);
      rr    = longint'(a) % longint'(b);
      res.q = qq[31:0];
      res.r = rr[15:0];
    end else begin
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      qq    = sa / sb;   // truncates toward zero
      rr    = sa % sb;   // takes the dividend's sign
      res.q = qq[31:0];
      res.r = rr[15:0];
    end
    return res;
  endfunction

  // Compare process: predicts handshakes at the coming edge and checks outputs
  // every cycle against the model's queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) begin
        chk("mon idle out_valid", {63'd0, out_valid}, 64'd0);
      end else if (out_valid) begin
        chk("mon result", {14'd0, quotient, remainder, dz, ovf}, {14'd0, exp_q[0]});
        chk("mon in_ready in DONE", {63'd0, in_ready}, 64'd0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) exp_q.push_back(model(dividend, divisor, sgn));
      end
    end
  end

  // lat = edges from the accept edge to the edge that raises out_valid.
  task automatic do_op(input logic [31:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] eq, input logic [15:0] er,
                       input logic edz, input logic eovf, input int hold, input int lat);
    int t0, n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready before request", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; dividend = a; divisor = b; sgn = s;
    @(posedge clk); #1;
    t0 = cyc;
    in_valid = 1'b0;
    dividend = $urandom(); divisor = 16'($urandom()); sgn = 1'($urandom());
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(cyc - t0), 64'(lat));
    chk("quotient", {32'd0, quotient}, {32'd0, eq});
    chk("remainder", {48'd0, remainder}, {48'd0, er});
    chk("dz/ovf", {62'd0, dz, ovf}, {62'd0, edz, eovf});
    $display("[TB] op a=0x%08h b=0x%04h sgn=%0d -> q=0x%08h r=0x%04h dz=%0d ovf=%0d lat=%0d",
             a, b, s, quotient, remainder, dz, ovf, cyc - t0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("held result", {13'd0, out_valid, quotient, remainder, dz, ovf},
          {13'd0, 1'b1, eq, er, edz, eovf});
      chk("in_ready held low", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid after handshake", {63'd0, out_valid}, 64'd0);
    chk("in_ready after handshake", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic do_op4(input logic [31:0] a, input logic [15:0] b, input logic s,
                        input logic [31:0] eq, input logic [15:0] er);
    int t0, n;
    res_t m;
    m = model(a, b, s);
    in_valid4 = 1'b1; dividend = a; divisor = b; sgn = s;
    @(posedge clk); #1;
    t0 = cyc;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 100) begin @(posedge clk); #1; n++; end
    chk("ipc4 latency", 64'(cyc - t0), 64'd9);
    chk("ipc4 literal", {16'd0, quotient4, remainder4}, {16'd0, eq, er});
    chk("ipc4 model", {14'd0, quotient4, remainder4, dz4, ovf4}, {14'd0, m});
    $display("[TB] ipc4 a=0x%08h b=0x%04h sgn=%0d -> q=0x%08h r=0x%04h lat=%0d",
             a, b, s, quotient4, remainder4, cyc - t0);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    chk("ipc4 in_ready after handshake", {63'd0, in_ready4}, 64'd1);
  endtask

  // Starts 100/7 and stops after ten CALC edges, leaving the caller to abort.
  task automatic start_and_run10();
    in_valid = 1'b1; dividend = 32'd100; divisor = 16'd7; sgn = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; dividend = '0; divisor = '0; sgn = 1'b0;
    flush = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset quotient", {32'd0, quotient}, 64'd0);
    chk("reset remainder", {48'd0, remainder}, 64'd0);
    chk("reset flags", {62'd0, dz, ovf}, 64'd0);
    chk("reset in_ready ipc4", {62'd0, in_ready4, out_valid4}, 64'd2);
    rst = 1'b0;
    @(posedge clk); #1;

    // hand-computed values pinning the model
    chk("model 100/7", {14'd0, model(32'd100, 16'd7, 1'b0)}, {14'd0, 32'd14, 16'd2, 2'b00});
    chk("model -7/2", {14'd0, model(32'hFFFF_FFF9, 16'd2, 1'b1)}, {14'd0, 32'hFFFF_FFFD, 16'hFFFF, 2'b00});
    chk("model dz", {14'd0, model(32'h1234_5678, 16'd0, 1'b0)}, {14'd0, 32'hFFFF_FFFF, 16'h5678, 2'b10});
    chk("model ovf", {14'd0, model(32'h8000_0000, 16'hFFFF, 1'b1)}, {14'd0, 32'h8000_0000, 16'h0, 2'b01});

    do_op(32'd100,        16'd7,     1'b0, 32'd14,        16'd2,     1'b0, 1'b0, 0, 33);
    do_op(32'hFFFF_FFF9,  16'h0002,  1'b1, 32'hFFFF_FFFD, 16'hFFFF,  1'b0, 1'b0, 0, 33);
    do_op(32'd7,          16'hFFFE,  1'b1, 32'hFFFF_FFFD, 16'h0001,  1'b0, 1'b0, 0, 33);
    do_op(32'h1234_5678,  16'h0000,  1'b0, 32'hFFFF_FFFF, 16'h5678,  1'b1, 1'b0, 0, 0);
    do_op(32'h8000_0000,  16'hFFFF,  1'b1, 32'h8000_0000, 16'h0000,  1'b0, 1'b1, 0, 0);
    do_op(32'hFFFF_FFFF,  16'hFFFF,  1'b0, 32'h0001_0001, 16'h0000,  1'b0, 1'b0, 0, 33);
    do_op(32'h8000_0000,  16'h0000,  1'b1, 32'hFFFF_FFFF, 16'h0000,  1'b1, 1'b0, 0, 0);
    do_op(32'hFFFF_FF9C,  16'hFFF9,  1'b1, 32'd14,        16'hFFFE,  1'b0, 1'b0, 0, 33);
    do_op(32'h8000_0000,  16'h8000,  1'b1, 32'h0001_0000, 16'h0000,  1'b0, 1'b0, 0, 33);
    do_op(32'h8000_0000,  16'hFFFF,  1'b0, 32'h0000_8000, 16'h8000,  1'b0, 1'b0, 0, 33);
    do_op(32'h8000_0000,  16'h0001,  1'b1, 32'h8000_0000, 16'h0000,  1'b0, 1'b0, 0, 33);

    // backpressure, then a back-to-back request
    do_op(32'd1000,       16'd3,     1'b0, 32'd333,       16'd1,     1'b0, 1'b0, 5, 33);
    do_op(32'hFFFF_FFFF,  16'h0001,  1'b0, 32'hFFFF_FFFF, 16'h0000,  1'b0, 1'b0, 0, 33);

    // flush mid-CALC
    start_and_run10();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    $display("[TB] flush at CALC cycle 10");
    repeat (40) begin @(posedge clk); #1; end
    do_op(32'd100, 16'd7, 1'b0, 32'd14, 16'd2, 1'b0, 1'b0, 0, 33);

    // asynchronous reset mid-CALC
    start_and_run10();
    #2 rst = 1'b1;
    #1;
    chk("async rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("async rst outputs", {13'd0, out_valid, quotient, remainder, dz, ovf}, 64'd0);
    $display("[TB] async reset at CALC cycle 10");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; end
    do_op(32'd100, 16'd7, 1'b0, 32'd14, 16'd2, 1'b0, 1'b0, 0, 33);

    // four quotient bits per clock
    do_op4(32'd100,       16'd7,    1'b0, 32'd14,        16'd2);
    do_op4(32'hFFFF_FFF9, 16'h0002, 1'b1, 32'hFFFF_FFFD, 16'hFFFF);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
